// File: rtl/seq_detect_ctrl.sv
// Serial pattern detector with a configurable pattern, match counter and target.
// Accepts config in IDLE/DONE, counts matches in RUN, stops in DONE on target.
module seq_detect_ctrl #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic [PAT_W-1:0] i_cfg_pattern,
    input  logic [3:0]       i_cfg_len,
    input  logic             i_cfg_overlap,
    input  logic [CNT_W-1:0] i_cfg_target,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_bit_valid,
    input  logic             i_bit,
    output logic             o_match,
    output logic [CNT_W-1:0] o_match_cnt,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state;
    logic [PAT_W-1:0] cfg_pat;
    logic [3:0]       cfg_len;
    logic             cfg_ov;
    logic [CNT_W-1:0] cfg_tgt;
    logic             cfg_loaded;
    logic [PAT_W-1:0] sr;
    logic [3:0]       fill;
    logic [CNT_W-1:0] cnt;
    logic             match_q;
    logic             err_q;

    logic             cfg_acc;
    logic             cfg_legal;
    logic             load_ok;
    logic             cfg_bad;
    logic             start_go;
    logic             start_bad;
    logic             bit_acc;
    logic [PAT_W-1:0] sr_nxt;
    logic [3:0]       fill_nxt;
    logic [PAT_W-1:0] len_mask;
    logic             hit;
    logic [CNT_W-1:0] cnt_inc;
    logic             tgt_hit;

    always_comb begin
        cfg_acc   = i_cfg_valid && (state != ST_RUN);
        cfg_legal = (i_cfg_len != 4'd0) && (32'(i_cfg_len) <= PAT_W);
        load_ok   = cfg_acc && cfg_legal;
        cfg_bad   = cfg_acc && !cfg_legal;
        // A legal config offered alongside start is used by that start.
        start_go  = i_start && (state != ST_RUN) && (cfg_loaded || load_ok);
        start_bad = i_start && (state != ST_RUN) && !(cfg_loaded || load_ok);
        bit_acc   = (state == ST_RUN) && i_bit_valid && !i_abort;
        sr_nxt    = {sr[PAT_W-2:0], i_bit};
        fill_nxt  = (fill == cfg_len) ? fill : fill + 4'd1;
        len_mask  = ~({PAT_W{1'b1}} << cfg_len);
        hit       = bit_acc && (fill_nxt == cfg_len)
                    && (((sr_nxt ^ cfg_pat) & len_mask) == '0);
        cnt_inc   = (cnt == '1) ? cnt : cnt + CNT_W'(1);
        tgt_hit   = (cfg_tgt != '0) && (cnt_inc == cfg_tgt);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            cfg_pat    <= '0;
            cfg_len    <= '0;
            cfg_ov     <= 1'b0;
            cfg_tgt    <= '0;
            cfg_loaded <= 1'b0;
            sr         <= '0;
            fill       <= '0;
            cnt        <= '0;
            match_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            match_q <= 1'b0;
            err_q   <= cfg_bad || start_bad;
            if (load_ok) begin
                cfg_pat    <= i_cfg_pattern;
                cfg_len    <= i_cfg_len;
                cfg_ov     <= i_cfg_overlap;
                cfg_tgt    <= i_cfg_target;
                cfg_loaded <= 1'b1;
            end
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_go) begin
                        state <= ST_RUN;
                        sr    <= '0;
                        fill  <= '0;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    if (i_abort) begin
                        state <= ST_IDLE;
                    end else if (bit_acc) begin
                        sr <= sr_nxt;
                        if (hit) begin
                            match_q <= 1'b1;
                            cnt     <= cnt_inc;
                            fill    <= cfg_ov ? fill_nxt : 4'd0;
                            if (tgt_hit) begin
                                state <= ST_DONE;
                            end
                        end else begin
                            fill <= fill_nxt;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_cfg_ready = (state != ST_RUN);
    assign o_busy      = (state == ST_RUN);
    assign o_done      = (state == ST_DONE);
    assign o_match     = match_q;
    assign o_match_cnt = cnt;
    assign o_err       = err_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: directed scenarios then random traffic,
// checked against a bit-window reference model.
module tb_seq_detect_ctrl;

    logic       clk;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic [7:0] cfg_target;
    logic       start;
    logic       abort_in;
    logic       bit_valid;
    logic       bit_in;
    logic       match;
    logic [7:0] match_cnt;
    logic       busy;
    logic       done;
    logic       err;

    seq_detect_ctrl #(.PAT_W(8), .CNT_W(8)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cfg_valid  (cfg_valid),
        .o_cfg_ready  (cfg_ready),
        .i_cfg_pattern(cfg_pattern),
        .i_cfg_len    (cfg_len),
        .i_cfg_overlap(cfg_overlap),
        .i_cfg_target (cfg_target),
        .i_start      (start),
        .i_abort      (abort_in),
        .i_bit_valid  (bit_valid),
        .i_bit        (bit_in),
        .o_match      (match),
        .o_match_cnt  (match_cnt),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       cv;
        logic [7:0] pat;
        int         len;
        logic       ov;
        int         tgt;
        logic       start;
        logic       abort;
        logic       bv;
        logic       b;
    } stim_t;

    typedef struct {
        logic       match;
        logic [7:0] cnt;
        logic       busy;
        logic       done;
        logic       err;
        logic       ready;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: mode 0=idle 1=run 2=done, last-len-bits window.
    int         m_mode = 0;
    logic [7:0] m_pat = 0;
    int         m_len = 0;
    logic       m_ov = 0;
    int         m_tgt = 0;
    logic       m_loaded = 0;
    int         m_cnt = 0;
    logic       win[$];

    task automatic model_step(input stim_t s);
        exp_t e;
        bit   eq;
        e.match = 1'b0;
        e.err   = 1'b0;
        if (s.rst) begin
            m_mode = 0; m_pat = 0; m_len = 0; m_ov = 0; m_tgt = 0;
            m_loaded = 0; m_cnt = 0; win.delete();
        end else if (m_mode != 1) begin
            if (s.cv) begin
                if (s.len >= 1 && s.len <= 8) begin
                    m_pat = s.pat; m_len = s.len; m_ov = s.ov;
                    m_tgt = s.tgt; m_loaded = 1;
                end else begin
                    e.err = 1'b1;
                end
            end
            if (s.start) begin
                if (m_loaded) begin
                    m_mode = 1; m_cnt = 0; win.delete();
                end else begin
                    e.err = 1'b1;
                end
            end
        end else if (s.abort) begin
            m_mode = 0;
        end else if (s.bv) begin
            win.push_back(s.b);
            if (win.size() > m_len) void'(win.pop_front());
            if (win.size() == m_len) begin
                eq = 1'b1;
                for (int k = 0; k < m_len; k++)
                    if (win[k] != m_pat[m_len-1-k]) eq = 1'b0;
                if (eq) begin
                    e.match = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                    if (!m_ov) win.delete();
                    if (m_tgt != 0 && m_cnt == m_tgt) m_mode = 2;
                end
            end
        end
        e.cnt   = 8'(m_cnt);
        e.busy  = (m_mode == 1);
        e.done  = (m_mode == 2);
        e.ready = (m_mode != 1);
        sbq.push_back(e);
    endtask

    task automatic drive(input stim_t s);
        @(negedge clk);
        rst         = s.rst;
        cfg_valid   = s.cv;
        cfg_pattern = s.pat;
        cfg_len     = 4'(s.len);
        cfg_overlap = s.ov;
        cfg_target  = 8'(s.tgt);
        start       = s.start;
        abort_in    = s.abort;
        bit_valid   = s.bv;
        bit_in      = s.b;
        model_step(s);
    endtask

    function automatic stim_t idle_s();
        stim_t s;
        s.rst = 0; s.cv = 0; s.pat = 0; s.len = 0; s.ov = 0; s.tgt = 0;
        s.start = 0; s.abort = 0; s.bv = 0; s.b = 0;
        return s;
    endfunction

    task automatic do_rst();
        stim_t s = idle_s();
        s.rst = 1;
        drive(s);
    endtask

    task automatic do_cfg(input logic [7:0] p, input int l, input logic o,
                          input int t, input logic st);
        stim_t s = idle_s();
        s.cv = 1; s.pat = p; s.len = l; s.ov = o; s.tgt = t; s.start = st;
        drive(s);
    endtask

    task automatic do_ctl(input logic st, input logic ab);
        stim_t s = idle_s();
        s.start = st; s.abort = ab;
        drive(s);
    endtask

    task automatic do_bit(input logic b, input logic ab);
        stim_t s = idle_s();
        s.bv = 1; s.b = b; s.abort = ab;
        drive(s);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected response per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("match", int'(match), int'(e.match));
                chk("match_cnt", int'(match_cnt), int'(e.cnt));
                chk("busy", int'(busy), int'(e.busy));
                chk("done", int'(done), int'(e.done));
                chk("err", int'(err), int'(e.err));
                chk("cfg_ready", int'(cfg_ready), int'(e.ready));
            end
        end
    end

    initial begin
        stim_t s;
        logic  b5[5];
        logic  b11[11];
        b5  = '{1, 0, 1, 0, 1};
        b11 = '{1, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1};
        rst = 1; cfg_valid = 0; cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0;
        cfg_target = 0; start = 0; abort_in = 0; bit_valid = 0; bit_in = 0;

        // Overlapping 101
        do_rst();
        do_cfg(8'b101, 3, 1, 0, 0);
        do_ctl(1, 0);
        foreach (b5[i]) do_bit(b5[i], 0);
        do_ctl(0, 0);
        do_ctl(0, 1);
        // Non-overlapping 101
        do_cfg(8'b101, 3, 0, 0, 0);
        do_ctl(1, 0);
        foreach (b5[i]) do_bit(b5[i], 0);
        do_ctl(0, 1);
        // Target 2 with 1011, extra bits ignored in DONE
        do_cfg(8'b1011, 4, 1, 2, 0);
        do_ctl(1, 0);
        foreach (b11[i]) do_bit(b11[i], 0);
        do_ctl(0, 1);
        do_ctl(0, 0);
        // Illegal config and start without config
        do_rst();
        do_cfg(8'hAA, 0, 0, 0, 0);
        do_ctl(1, 0);
        do_cfg(8'hAA, 9, 0, 0, 1);
        // Config and start together, then abort colliding with a bit
        do_cfg(8'b11, 2, 1, 0, 1);
        do_bit(1, 0);
        do_bit(1, 1);
        do_ctl(0, 0);
        // Illegal config with start uses the prior config
        do_cfg(8'h00, 12, 0, 0, 1);
        do_bit(1, 0);
        s = idle_s();
        drive(s);
        do_bit(1, 0);
        // Reset mid-run clears config
        do_rst();
        do_ctl(1, 0);
        do_ctl(0, 0);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            s = idle_s();
            s.rst   = ($urandom_range(0, 399) == 0);
            s.cv    = ($urandom_range(0, 19) == 0);
            s.len   = (s.cv && $urandom_range(0, 9) == 0) ?
                      int'($urandom_range(0, 15)) : int'($urandom_range(1, 4));
            s.pat   = 8'($urandom());
            s.ov    = 1'($urandom());
            s.tgt   = int'($urandom_range(0, 5));
            s.start = ($urandom_range(0, 24) == 0);
            s.abort = ($urandom_range(0, 79) == 0);
            s.bv    = ($urandom_range(0, 2) != 0);
            s.b     = 1'($urandom());
            drive(s);
        end

        s = idle_s();
        drive(s);
        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
        #3;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 Parameter PAT_W, default 8: maximum pattern length in bits.
REQ-002 Parameter CNT_W, default 8: match counter and target width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with all state updating on the rising edge of i_clk.
REQ-004 Ports SHALL be, as name, direction, width, meaning:
- i_clk, in, 1: clock.
- i_rst, in, 1: synchronous active-high reset.
- i_cfg_valid, in, 1: configuration offered.
- o_cfg_ready, out, 1: configuration accepted this cycle if valid.
- i_cfg_pattern, in, PAT_W: pattern; bit [len-1] is received first and bit [0] last.
- i_cfg_len, in, 4: pattern length, legal range 1..PAT_W.
- i_cfg_overlap, in, 1: 1 means overlapping matches are allowed.
- i_cfg_target, in, CNT_W: matches to reach DONE; 0 means unlimited.
- i_start, in, 1: start a detection run.
- i_abort, in, 1: abort the current run.
- i_bit_valid, in, 1: serial bit qualifier.
- i_bit, in, 1: serial data bit.
- o_match, out, 1: one-cycle match pulse.
- o_match_cnt, out, CNT_W: matches counted in the current run.
- o_busy, out, 1: state is RUN.
- o_done, out, 1: state is DONE (level).
- o_err, out, 1: one-cycle pulse on an illegal config or on start without a config.

Function
REQ-005 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-006 o_cfg_ready SHALL be 1 in IDLE and DONE and 0 in RUN.
REQ-007 When i_cfg_valid & o_cfg_ready and 1 <= i_cfg_len <= PAT_W, the block SHALL register pattern, len, overlap and target and set the internal flag cfg_loaded.
REQ-008 When i_cfg_valid & o_cfg_ready and i_cfg_len is 0 or greater than PAT_W, the block SHALL pulse o_err for one cycle and leave the stored config and cfg_loaded unchanged.
REQ-009 i_start in IDLE or DONE with cfg_loaded SHALL move the FSM to RUN, clear the shift register, fill counter and o_match_cnt, and leave o_done at 0.
REQ-010 i_start with cfg_loaded=0 SHALL pulse o_err and leave the state unchanged.
REQ-011 When config and i_start are presented in the same cycle, the config SHALL be applied first and the run SHALL use the new config; if that config is illegal, o_err SHALL pulse once and the start SHALL be evaluated against the prior cfg_loaded.
REQ-012 In RUN, each i_bit_valid cycle SHALL shift i_bit into a PAT_W-bit shift register at the LSB and increment a fill counter that saturates at len.
REQ-013 A match SHALL be detected when the post-shift fill counter equals len and the low len bits of the shift register equal the low len bits of the pattern.
REQ-014 o_match SHALL be registered and SHALL assert exactly one cycle after the edge that accepted the matching bit.
REQ-015 On a match, o_match_cnt SHALL increment, saturating at 2^CNT_W-1, and the fill counter SHALL be cleared to 0 when overlap=0 and left unchanged when overlap=1.
REQ-016 When the incremented count equals a nonzero target, the FSM SHALL go to DONE on the same edge; further bits SHALL be ignored in DONE and o_match_cnt SHALL hold.
REQ-017 Cycles with i_bit_valid=0 SHALL change no datapath state.
REQ-018 i_abort in RUN SHALL return the FSM to IDLE, hold o_match_cnt, and keep o_done at 0.
REQ-019 i_abort SHALL take priority over a bit accepted in the same cycle: that bit is discarded and produces no match.
REQ-020 i_abort in IDLE or DONE SHALL be ignored.
REQ-021 i_start during RUN SHALL be ignored.
REQ-022 o_busy and o_done SHALL be decoded from the registered state.

Reset
REQ-023 With i_rst=1 at a clock edge, the block SHALL enter IDLE, clear the stored config, cfg_loaded, shift register, fill counter and o_match_cnt, and drive o_match, o_busy, o_done and o_err to 0 and o_cfg_ready to 1 on the next cycle.
REQ-024 Reset SHALL override every other input, including in the middle of a run.

Verification
REQ-025 Overlap: pattern 3'b101, len 3, overlap 1, target 0, start, bits 1,0,1,0,1 -> o_match pulses after bits 3 and 5, o_match_cnt=2, o_busy=1.
REQ-026 Non-overlap: same stimulus with overlap 0 -> single o_match after bit 3, o_match_cnt=1.
REQ-027 Target: pattern 4'b1011, len 4, overlap 1, target 2, bits 1,0,1,1,0,1,1,1,0,1,1 -> matches after bits 4 and 7, o_done=1 and o_busy=0 from the cycle after bit 7, o_match_cnt stays 2, no further o_match.
REQ-028 Illegal config and start without config: after reset, cfg len 0 -> o_err one cycle, o_cfg_ready stays 1; then i_start -> o_err one cycle, state stays IDLE.
REQ-029 Abort collision: pattern 2'b11, len 2, bits 1 then 1 with i_abort in the cycle of the second bit -> no o_match, IDLE next cycle, o_match_cnt=0.
REQ-030 Reset mid-run: after 1 match, assert i_rst for one cycle -> o_match_cnt=0, o_busy=0, cfg_loaded cleared; a following i_start -> o_err.
